// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Responder side of the control unit's fetch interface. Owns the
//               program counter, the instruction memory and the instruction
//               register. Executes PC_CLR / PC_IC / IR_LD commands and returns
//               the fetched word on IR, qualified by IR_VALID. The instruction
//               memory is loaded through a dedicated program-write port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PC_W        program counter width (bits)
//   IR_W        instruction word width (bits)
//   IMEM_DEPTH  instruction words implemented (must be <= 2**PC_W)
// Optional feature macro
//   FETCH_JUMP_EN  adds PC_LD / PC_LD_VAL for absolute PC loads
// Ports
//   Clock      in   1     clock, all state updates on posedge
//   Reset      in   1     synchronous, active-high reset
//   PC_CLR     in   1     clear PC to 0 (also clears FETCH_ERR)
//   PC_IC      in   1     increment PC by 1 (wraps silently)
//   IR_LD      in   1     start a fetch of mem[PC] into IR
//   PC_LD      in   1     (FETCH_JUMP_EN) load PC from PC_LD_VAL
//   PC_LD_VAL  in   PC_W  (FETCH_JUMP_EN) PC load value
//   PROG_WE    in   1     instruction memory write enable
//   PROG_ADDR  in   PC_W  instruction memory write address
//   PROG_DATA  in   IR_W  instruction memory write data
//   PC         out  PC_W  current program counter
//   IR         out  IR_W  instruction register
//   IR_VALID   out  1     IR holds the result of the latest accepted fetch
//   FETCH_ERR  out  1     sticky: a fetch was issued with PC >= IMEM_DEPTH
// ============================================================================
module instruction_fetch_unit #(
  parameter int PC_W       = 8,
  parameter int IR_W       = 16,
  parameter int IMEM_DEPTH = 256
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            PC_CLR,
  input  logic            PC_IC,
  input  logic            IR_LD,
`ifdef FETCH_JUMP_EN
  input  logic            PC_LD,
  input  logic [PC_W-1:0] PC_LD_VAL,
`endif
  input  logic            PROG_WE,
  input  logic [PC_W-1:0] PROG_ADDR,
  input  logic [IR_W-1:0] PROG_DATA,
  output logic [PC_W-1:0] PC,
  output logic [IR_W-1:0] IR,
  output logic            IR_VALID,
  output logic            FETCH_ERR
);

  // Memory index width; IMEM_DEPTH <= 2**PC_W guarantees ADDR_W <= PC_W.
  localparam int ADDR_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  // Depth expressed one bit wider than PC so a full 2**PC_W depth is representable.
  localparam logic [PC_W:0] DEPTH = (PC_W + 1)'(IMEM_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_next;
  logic            fetch_accept;
  logic            ir_capture;

  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] fa;          // latched fetch address of the in-flight fetch
  logic [IR_W-1:0] rd_data;     // synchronous read port output
  logic            pc_oob;
  logic            fa_oob;
  logic            prog_in_range;

  logic [IR_W-1:0] mem [IMEM_DEPTH];

  assign pc_oob        = {1'b0, PC} >= DEPTH;
  assign fa_oob        = {1'b0, fa} >= DEPTH;
  assign prog_in_range = {1'b0, PROG_ADDR} < DEPTH;

  // --------------------------------------------------------------------------
  // Fetch FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: next-state logic. IR_LD seen in WAIT is simply dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (IR_LD) state_next = ST_WAIT;
      ST_WAIT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_accept = 1'b0;
    ir_capture   = 1'b0;
    case (state)
      ST_IDLE: fetch_accept = IR_LD;
      ST_WAIT: ir_capture   = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Program counter: PC_CLR > PC_LD > PC_IC (Reset handled in the register).
  // --------------------------------------------------------------------------
  always_comb begin
    pc_next = PC;
    if (PC_CLR) begin
      pc_next = '0;
    end
`ifdef FETCH_JUMP_EN
    else if (PC_LD) begin
      pc_next = PC_LD_VAL;
    end
`endif
    else if (PC_IC) begin
      pc_next = PC + PC_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      PC <= '0;
    end else begin
      PC <= pc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction memory. Not reset. The read samples the array before this
  // edge's write lands, giving read-before-write on an address collision.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (PROG_WE && prog_in_range) begin
      mem[PROG_ADDR[ADDR_W-1:0]] <= PROG_DATA;
    end
  end

  always_ff @(posedge Clock) begin
    if (fetch_accept && !pc_oob) begin
      rd_data <= mem[PC[ADDR_W-1:0]];
    end
  end

  // Fetch address is captured at accept so later PC moves cannot affect it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fa <= '0;
    end else if (fetch_accept) begin
      fa <= PC;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction register and its qualifier
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      IR       <= '0;
      IR_VALID <= 1'b0;
    end else if (fetch_accept) begin
      IR_VALID <= 1'b0;
    end else if (ir_capture) begin
      IR       <= fa_oob ? '0 : rd_data;
      IR_VALID <= 1'b1;
    end
  end

  // Sticky error; an out-of-range fetch beats a simultaneous PC_CLR.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      FETCH_ERR <= 1'b0;
    end else if (fetch_accept && pc_oob) begin
      FETCH_ERR <= 1'b1;
    end else if (PC_CLR) begin
      FETCH_ERR <= 1'b0;
    end
  end

endmodule
`default_nettype wire
